keypad_scan: RTL and testbench

- Input-side counterpart to the multiplexed seven-segment display driver: time-multiplexed scanner for a 4x4 matrix keypad.
- Drives one column low at a time, samples the four row lines and debounces any press.
- Emits a one-cycle key_valid strobe with a 4-bit hex key code.
- Feeds the stopwatch/top level as a replacement for the sw/mode switch inputs. Sits beside the clock divider and display mux, in the same clk domain.

---
 rtl/keypad_pkg.sv | 58 +++++
 rtl/keypad_sync.sv | 28 ++
 rtl/keypad_scan.sv | 183 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Holds the FSM state encoding, the hex keymap and column/row helpers.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   localparam logic [3:0] COL_IDLE = 4'b1110;

   // Keymap: row 3 carries '*' as E and '#' as F.
   function automatic logic [3:0] code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0:    k = 4'h1;
         4'h1:    k = 4'h2;
         4'h2:    k = 4'h3;
         4'h3:    k = 4'hA;
         4'h4:    k = 4'h4;
         4'h5:    k = 4'h5;
         4'h6:    k = 4'h6;
         4'h7:    k = 4'hB;
         4'h8:    k = 4'h7;
         4'h9:    k = 4'h8;
         4'hA:    k = 4'h9;
         4'hB:    k = 4'hC;
         4'hC:    k = 4'hE;
         4'hD:    k = 4'h0;
         4'hE:    k = 4'hF;
         4'hF:    k = 4'hD;
         default: k = 4'h0;
      endcase
      return k;
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] c);
      return ~(4'b0001 << c);
   endfunction

   // Lowest-index active-low row wins; result is don't-care when all rows are high.
   function automatic logic [1:0] first_low(input logic [3:0] rows);
      logic [1:0] r;
      if (rows[0] == 1'b0) begin
         r = 2'd0;
      end else if (rows[1] == 1'b0) begin
         r = 2'd1;
      end else if (rows[2] == 1'b0) begin
         r = 2'd2;
      end else begin
         r = 2'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
// Resets to all-high so an idle keypad is seen immediately after reset.
module keypad_sync
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta_r;
   logic [3:0] sync_r;

   // Metastability chain for the row inputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta_r <= 4'b1111;
         sync_r <= 4'b1111;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/keypad_scan.sv
// Time-multiplexed 4x4 keypad scanner: drives one column low per dwell period,
// debounces presses and releases on end-of-dwell samples, and strobes the key code.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 50000,
   parameter int DEBOUNCE_N = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_N + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
   localparam logic [DW-1:0] DWELL_ZERO = DW'(0);
   localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_N);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

   logic [3:0]    row_s;
   logic          sample_s;
   logic          any_low_s;
   logic [1:0]    win_row_s;
   logic [CW-1:0] cnt_inc_s;

   logic [DW-1:0] dwell_r;
   scan_state_t   state_r,     state_n;
   logic [1:0]    col_idx_r,   col_idx_n;
   logic [1:0]    cand_row_r,  cand_row_n;
   logic [CW-1:0] cnt_r,       cnt_n;
   logic [3:0]    col_r,       col_n;
   logic [3:0]    key_code_r,  key_code_n;
   logic          key_valid_r, key_valid_n;
   logic          key_held_r,  key_held_n;

   keypad_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row),
      .q     (row_s)
   );

   assign sample_s  = (dwell_r == DWELL_LAST);
   assign any_low_s = (row_s != 4'b1111);
   assign win_row_s = first_low(row_s);
   assign cnt_inc_s = cnt_r + CNT_ONE;

   // Dwell counter: one sample per column period.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dwell_r <= DWELL_ZERO;
      end else if (sample_s) begin
         dwell_r <= DWELL_ZERO;
      end else begin
         dwell_r <= dwell_r + DWELL_ONE;
      end
   end

   // FSM and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= SCAN;
         col_idx_r   <= 2'd0;
         cand_row_r  <= 2'd0;
         cnt_r       <= CNT_ZERO;
         col_r       <= COL_IDLE;
         key_code_r  <= 4'h0;
         key_valid_r <= 1'b0;
         key_held_r  <= 1'b0;
      end else begin
         state_r     <= state_n;
         col_idx_r   <= col_idx_n;
         cand_row_r  <= cand_row_n;
         cnt_r       <= cnt_n;
         col_r       <= col_n;
         key_code_r  <= key_code_n;
         key_valid_r <= key_valid_n;
         key_held_r  <= key_held_n;
      end
   end

   // Next-state logic; column is frozen everywhere except on SCAN advance and exits to SCAN.
   always_comb begin
      state_n     = state_r;
      col_idx_n   = col_idx_r;
      cand_row_n  = cand_row_r;
      cnt_n       = cnt_r;
      key_code_n  = key_code_r;
      key_valid_n = 1'b0;
      key_held_n  = key_held_r;

      if (sample_s) begin
         case (state_r)
            SCAN: begin
               if (any_low_s) begin
                  cand_row_n = win_row_s;
                  if (DEBOUNCE_N == 1) begin
                     state_n     = PRESSED;
                     cnt_n       = CNT_ZERO;
                     key_valid_n = 1'b1;
                     key_code_n  = code(win_row_s, col_idx_r);
                     key_held_n  = 1'b1;
                  end else begin
                     state_n = DEBOUNCE;
                     cnt_n   = CNT_ONE;
                  end
               end else begin
                  col_idx_n = col_idx_r + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (any_low_s && (win_row_s == cand_row_r)) begin
                  if (cnt_inc_s == DEB_TARGET) begin
                     state_n     = PRESSED;
                     cnt_n       = CNT_ZERO;
                     key_valid_n = 1'b1;
                     key_code_n  = code(cand_row_r, col_idx_r);
                     key_held_n  = 1'b1;
                  end else begin
                     cnt_n = cnt_inc_s;
                  end
               end else begin
                  state_n   = SCAN;
                  cnt_n     = CNT_ZERO;
                  col_idx_n = col_idx_r + 2'd1;
               end
            end
            PRESSED: begin
               if (!any_low_s) begin
                  if (DEBOUNCE_N == 1) begin
                     state_n    = SCAN;
                     cnt_n      = CNT_ZERO;
                     key_held_n = 1'b0;
                     col_idx_n  = col_idx_r + 2'd1;
                  end else begin
                     state_n = RELEASE;
                     cnt_n   = CNT_ONE;
                  end
               end else begin
                  state_n = PRESSED;
               end
            end
            RELEASE: begin
               if (!any_low_s) begin
                  if (cnt_inc_s == DEB_TARGET) begin
                     state_n    = SCAN;
                     cnt_n      = CNT_ZERO;
                     key_held_n = 1'b0;
                     col_idx_n  = col_idx_r + 2'd1;
                  end else begin
                     cnt_n = cnt_inc_s;
                  end
               end else begin
                  state_n = PRESSED;
                  cnt_n   = CNT_ZERO;
               end
            end
            default: begin
               state_n   = SCAN;
               cnt_n     = CNT_ZERO;
               col_idx_n = 2'd0;
            end
         endcase
      end else begin
         state_n = state_r;
      end

      col_n = col_drive(col_idx_n);
   end

   assign col       = col_r;
   assign key_code  = key_code_r;
   assign key_valid = key_valid_r;
   assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a switch-matrix model on row/col and
// a queue of expected key codes consumed on every key_valid strobe.
module tb_keypad_scan;

   logic       clk;
   logic       reset;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [3:0][3:0] keys;
   logic [3:0]      exp_q[$];
   logic [3:0]      exp_code;
   logic [3:0]      one_hot;
   int              checks;
   int              errors;
   int              n_valid;
   logic            got_valid;

   keypad_scan #(
      .SCAN_DIV   (4),
      .DEBOUNCE_N (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Switch matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r][c] && (col[c] == 1'b0)) row[r] = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; every key_valid strobe is matched against the expectation queue.
   task automatic tick();
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) begin
         n_valid++;
         got_valid = 1'b1;
         checks++;
         assert (exp_q.size() > 0)
         else begin
            errors++;
            $error("FAIL unexpected_valid observed key_code=%h expected no strobe", key_code);
         end
         if (exp_q.size() > 0) begin
            exp_code = exp_q.pop_front();
            chk("key_code_on_valid", key_code, exp_code);
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      got_valid = 1'b0;
      while (!got_valid && (n < budget)) begin
         tick();
         n++;
      end
      checks++;
      assert (got_valid)
      else begin
         errors++;
         $error("FAIL %s observed=no key_valid expected=key_valid within %0d cycles", tag, budget);
      end
   endtask

   task automatic wait_held_low(input string tag, input int budget);
      int n;
      n = 0;
      while ((key_held !== 1'b0) && (n < budget)) begin
         tick();
         n++;
      end
      chk(tag, {3'b000, key_held}, 4'h0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      n_valid = 0;
      got_valid = 1'b0;
      one_hot = 4'b0001;
      keys  = '0;
      reset = 1'b0;

      // Reset for two cycles
      ticks(2);
      chk("reset_col", col, 4'b1110);
      chk("reset_code", key_code, 4'h0);
      chk("reset_valid", {3'b000, key_valid}, 4'h0);
      chk("reset_held", {3'b000, key_held}, 4'h0);
      reset = 1'b1;

      // Idle scan: 4 cycles per column, wrapping back to column 0
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("idle_col", col, ~(one_hot << ((k / 4) % 4)));
      end

      // Steady press of '5' (r1,c1)
      keys[1][1] = 1'b1;
      exp_q.push_back(4'h5);
      wait_valid("press5_valid", 100);
      chk("press5_col", col, 4'b1101);
      chk("press5_held", {3'b000, key_held}, 4'h1);
      ticks(8);
      chk("press5_hold_col", col, 4'b1101);
      chk("press5_hold_held", {3'b000, key_held}, 4'h1);
      chk("press5_count", n_valid[3:0], 4'h1);

      // Release '5' with a one-sample re-touch during RELEASE
      keys[1][1] = 1'b0;
      ticks(4);
      keys[1][1] = 1'b1;
      ticks(4);
      keys[1][1] = 1'b0;
      chk("retouch_held", {3'b000, key_held}, 4'h1);
      ticks(11);
      chk("release_pending_held", {3'b000, key_held}, 4'h1);
      chk("release_pending_col", col, 4'b1101);
      tick();
      chk("release_held", {3'b000, key_held}, 4'h0);
      chk("release_col", col, 4'b1011);

      // Bounce on '9' (r2,c2): seen on one sample only
      keys[2][2] = 1'b1;
      ticks(4);
      chk("bounce_frozen_col", col, 4'b1011);
      keys[2][2] = 1'b0;
      ticks(4);
      chk("bounce_col", col, 4'b0111);
      chk("bounce_held", {3'b000, key_held}, 4'h0);
      ticks(8);
      chk("bounce_count", n_valid[3:0], 4'h1);

      // '1' and '7' together on column 0: lower row wins
      keys[0][0] = 1'b1;
      keys[2][0] = 1'b1;
      exp_q.push_back(4'h1);
      wait_valid("multi_valid", 100);
      chk("multi_code", key_code, 4'h1);
      chk("multi_col", col, 4'b1110);
      keys[0][0] = 1'b0;
      keys[2][0] = 1'b0;
      wait_held_low("multi_release", 100);

      // '*' maps to E, then reset while it is held
      keys[3][0] = 1'b1;
      exp_q.push_back(4'hE);
      wait_valid("star_valid", 100);
      chk("star_code", key_code, 4'hE);
      chk("star_held", {3'b000, key_held}, 4'h1);
      reset = 1'b0;
      tick();
      chk("midreset_held", {3'b000, key_held}, 4'h0);
      chk("midreset_col", col, 4'b1110);
      chk("midreset_valid", {3'b000, key_valid}, 4'h0);
      chk("midreset_code", key_code, 4'h0);
      tick();
      reset = 1'b1;
      keys  = '0;
      ticks(20);

      chk("total_valid", n_valid[3:0], 4'h3);
      checks++;
      assert (exp_q.size() == 0)
      else begin
         errors++;
         $error("FAIL missing_valid observed=%0d pending expected=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
